// File: rtl/wb_can_tx_mailbox.sv
// rtl/wb_can_tx_mailbox.sv - multi-mailbox CAN transmit queue with Wishbone slave
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_adr_i .. wb_dat_o        Wishbone slave (byte address, word index adr[7:2])
//   tx_pkt_ready, tx_ID, tx_pkt_size, tx_RTR, tx_EXT, tx_data   frame offered to TCU
//   tx_done, tx_arb_loss        TCU result pulses for the offered frame
//   irq_o                       level interrupt from DONE/LOST and their enables
module wb_can_tx_mailbox #(
   parameter int NUM_MBOX  = 4,
   parameter int MAX_RETRY = 0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        tx_pkt_ready,
   output logic [28:0] tx_ID,
   output logic [3:0]  tx_pkt_size,
   output logic        tx_RTR,
   output logic        tx_EXT,
   output logic [63:0] tx_data,
   input  logic        tx_done,
   input  logic        tx_arb_loss,
   output logic        irq_o
);

   localparam int IW = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SELECT = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   localparam logic [5:0] W_STATUS = 6'(4 * NUM_MBOX);
   localparam logic [5:0] W_W1C    = 6'(4 * NUM_MBOX + 1);
   localparam logic [5:0] W_IE     = 6'(4 * NUM_MBOX + 2);

   // Lower key wins arbitration on the CAN bus; standard frames beat extended
   // frames with the same base ID because of the SRR/IDE recessive bits.
   function automatic logic [31:0] prio_key(input logic [28:0] id, input logic ext,
                                            input logic rtr);
      if (ext)
         return {id[28:18], 1'b1, 1'b1, id[17:0], rtr};
      else
         return {id[10:0], rtr, 1'b0, 19'b0};
   endfunction

   logic [1:0]          state;
   logic [28:0]         mb_id   [NUM_MBOX];
   logic                mb_ext  [NUM_MBOX];
   logic                mb_rtr  [NUM_MBOX];
   logic [3:0]          mb_dlc  [NUM_MBOX];
   logic [31:0]         mb_dl   [NUM_MBOX];
   logic [31:0]         mb_dh   [NUM_MBOX];
   logic [7:0]          retry_cnt [NUM_MBOX];
   logic [NUM_MBOX-1:0] pend, done, lost, done_ie, lost_ie;
   logic [IW-1:0]       active_idx;
   logic                abort_flag;

   // Bus decode
   logic          bus_acc, bus_wr, mb_hit;
   logic [5:0]    word;
   logic [IW-1:0] mb_sel;
   logic [1:0]    mb_reg;
   logic [31:0]   byte_mask, mb_word, merged, rd_data, status_word;
   logic          unused_ok;

   assign bus_acc   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign bus_wr    = bus_acc & wb_we_i;
   assign word      = wb_adr_i[7:2];
   assign mb_hit    = (word[5:2] < 4'(NUM_MBOX));
   assign mb_sel    = word[2 +: IW];
   assign mb_reg    = word[1:0];
   assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign unused_ok = &{1'b0, wb_adr_i[31:8], wb_adr_i[1:0]};

   assign status_word = {4'b0, (state != ST_IDLE), 3'(active_idx),
                         8'(lost), 8'(done), 8'(pend)};

   always_comb begin
      mb_word = '0;
      if (mb_hit) begin
         case (mb_reg)
            2'd0:    mb_word = {1'b0, mb_rtr[mb_sel], mb_ext[mb_sel], mb_id[mb_sel]};
            2'd1:    mb_word = {28'b0, mb_dlc[mb_sel]};
            2'd2:    mb_word = mb_dl[mb_sel];
            default: mb_word = mb_dh[mb_sel];
         endcase
      end
      rd_data = mb_word;
      if (!mb_hit) begin
         if (word == W_STATUS)
            rd_data = status_word;
         else if (word == W_IE)
            rd_data = {16'b0, 8'(lost_ie), 8'(done_ie)};
      end
   end

   // Byte-lane merge of write data into the addressed mailbox register
   assign merged = (mb_word & ~byte_mask) | (wb_dat_i & byte_mask);

   // Per-mailbox write strobes
   logic [NUM_MBOX-1:0] wr_mb, req_w, abort_w;
   always_comb begin
      for (int m = 0; m < NUM_MBOX; m++) begin
         wr_mb[m]   = bus_wr & mb_hit & (mb_sel == IW'(m));
         req_w[m]   = wr_mb[m] & (mb_reg == 2'd1) & wb_sel_i[1] & wb_dat_i[8];
         abort_w[m] = wr_mb[m] & (mb_reg == 2'd1) & wb_sel_i[1] & wb_dat_i[9];
      end
   end

   // Winner among pending mailboxes; strict compare keeps the lowest index on ties
   logic          win_any;
   logic [IW-1:0] win_idx;
   logic [31:0]   win_key;
   always_comb begin
      win_any = 1'b0;
      win_idx = '0;
      win_key = '1;
      for (int m = 0; m < NUM_MBOX; m++) begin
         if (pend[m] && (!win_any || prio_key(mb_id[m], mb_ext[m], mb_rtr[m]) < win_key)) begin
            win_any = 1'b1;
            win_idx = IW'(m);
            win_key = prio_key(mb_id[m], mb_ext[m], mb_rtr[m]);
         end
      end
   end

   // The mailbox being selected counts as active so an abort during SELECT is deferred
   logic          cur_busy, cur_abort, retry_limit;
   logic [IW-1:0] cur_idx;
   assign cur_busy    = ((state == ST_SELECT) && win_any) || (state == ST_ACTIVE);
   assign cur_idx     = (state == ST_SELECT) ? win_idx : active_idx;
   assign cur_abort   = cur_busy & abort_w[cur_idx];
   assign retry_limit = (MAX_RETRY != 0) &&
                        ((retry_cnt[active_idx] + 8'd1) == 8'(MAX_RETRY));

   logic [NUM_MBOX-1:0] pend_n, done_set, lost_set, cnt_clr, cnt_inc, w1c_done, w1c_lost;
   always_comb begin
      pend_n   = pend;
      done_set = '0;
      lost_set = '0;
      cnt_clr  = '0;
      cnt_inc  = '0;
      for (int m = 0; m < NUM_MBOX; m++) begin
         if (abort_w[m]) begin
            if (pend[m] && !(cur_busy && (cur_idx == IW'(m)))) begin
               pend_n[m]   = 1'b0;
               lost_set[m] = 1'b1;
               cnt_clr[m]  = 1'b1;
            end
         end else if (req_w[m] && !pend[m]) begin
            pend_n[m]  = 1'b1;
            cnt_clr[m] = 1'b1;
         end
      end
      if (state == ST_ACTIVE) begin
         if (tx_done) begin
            pend_n[active_idx]   = 1'b0;
            done_set[active_idx] = 1'b1;
            cnt_clr[active_idx]  = 1'b1;
         end else if (tx_arb_loss) begin
            if (abort_flag || cur_abort || retry_limit) begin
               pend_n[active_idx]   = 1'b0;
               lost_set[active_idx] = 1'b1;
               cnt_clr[active_idx]  = 1'b1;
            end else begin
               cnt_inc[active_idx] = 1'b1;
            end
         end
      end
      w1c_done = (bus_wr && (word == W_W1C) && wb_sel_i[1]) ? wb_dat_i[8 +: NUM_MBOX]  : '0;
      w1c_lost = (bus_wr && (word == W_W1C) && wb_sel_i[2]) ? wb_dat_i[16 +: NUM_MBOX] : '0;
   end

   assign tx_pkt_ready = (state == ST_ACTIVE);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= ST_IDLE;
         pend        <= '0;
         done        <= '0;
         lost        <= '0;
         done_ie     <= '0;
         lost_ie     <= '0;
         active_idx  <= '0;
         abort_flag  <= 1'b0;
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
         irq_o       <= 1'b0;
         tx_ID       <= '0;
         tx_pkt_size <= '0;
         tx_RTR      <= 1'b0;
         tx_EXT      <= 1'b0;
         tx_data     <= '0;
         for (int m = 0; m < NUM_MBOX; m++) begin
            mb_id[m]     <= '0;
            mb_ext[m]    <= 1'b0;
            mb_rtr[m]    <= 1'b0;
            mb_dlc[m]    <= '0;
            mb_dl[m]     <= '0;
            mb_dh[m]     <= '0;
            retry_cnt[m] <= '0;
         end
      end else begin
         wb_ack_o <= bus_acc;
         wb_dat_o <= (bus_acc && !wb_we_i) ? rd_data : '0;

         pend  <= pend_n;
         // Hardware set is OR-ed in after the clear so it wins a same-cycle W1C
         done  <= (done & ~w1c_done) | done_set;
         lost  <= (lost & ~w1c_lost) | lost_set;
         irq_o <= |((done & done_ie) | (lost & lost_ie));

         if (bus_wr && (word == W_IE)) begin
            if (wb_sel_i[0]) done_ie <= wb_dat_i[NUM_MBOX-1:0];
            if (wb_sel_i[1]) lost_ie <= wb_dat_i[8 +: NUM_MBOX];
         end

         for (int m = 0; m < NUM_MBOX; m++) begin
            if (cnt_clr[m])
               retry_cnt[m] <= '0;
            else if (cnt_inc[m])
               retry_cnt[m] <= retry_cnt[m] + 8'd1;

            // Frame fields are frozen while the mailbox is pending
            if (wr_mb[m] && !pend[m]) begin
               case (mb_reg)
                  2'd0: begin
                     mb_id[m]  <= merged[28:0];
                     mb_ext[m] <= merged[29];
                     mb_rtr[m] <= merged[30];
                  end
                  2'd1:    if (wb_sel_i[0]) mb_dlc[m] <= wb_dat_i[3:0];
                  2'd2:    mb_dl[m] <= merged;
                  default: mb_dh[m] <= merged;
               endcase
            end
         end

         case (state)
            ST_IDLE: begin
               if (|pend) state <= ST_SELECT;
            end
            ST_SELECT: begin
               if (win_any) begin
                  active_idx  <= win_idx;
                  tx_ID       <= mb_id[win_idx];
                  tx_EXT      <= mb_ext[win_idx];
                  tx_RTR      <= mb_rtr[win_idx];
                  tx_pkt_size <= mb_dlc[win_idx];
                  tx_data     <= {mb_dh[win_idx], mb_dl[win_idx]};
                  abort_flag  <= abort_w[win_idx];
                  state       <= ST_ACTIVE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               if (tx_done || tx_arb_loss) begin
                  abort_flag <= 1'b0;
                  state      <= ST_IDLE;
               end else if (abort_w[active_idx]) begin
                  abort_flag <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_can_tx_mailbox.sv
// tb/tb_wb_can_tx_mailbox.sv - self-checking bench for wb_can_tx_mailbox
module tb_wb_can_tx_mailbox;
   localparam int NMB  = 4;
   localparam int MAXR = 3;
   localparam logic [31:0] A_STATUS = 32'(16 * NMB);
   localparam logic [31:0] A_W1C    = 32'(16 * NMB + 4);
   localparam logic [31:0] A_IE     = 32'(16 * NMB + 8);

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        tx_pkt_ready, tx_RTR, tx_EXT, irq_o;
   logic [28:0] tx_ID;
   logic [3:0]  tx_pkt_size;
   logic [63:0] tx_data;
   logic        tx_done = 1'b0, tx_arb_loss = 1'b0;

   always #5 clk = ~clk;

   wb_can_tx_mailbox #(.NUM_MBOX(NMB), .MAX_RETRY(MAXR)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .tx_pkt_ready(tx_pkt_ready), .tx_ID(tx_ID),
      .tx_pkt_size(tx_pkt_size), .tx_RTR(tx_RTR), .tx_EXT(tx_EXT), .tx_data(tx_data),
      .tx_done(tx_done), .tx_arb_loss(tx_arb_loss), .irq_o(irq_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: mailbox contents and flags, plus which frame the TCU sees
   logic [28:0]    m_id [NMB];
   logic           m_ext[NMB], m_rtr[NMB];
   logic [3:0]     m_dlc[NMB];
   logic [31:0]    m_dl [NMB], m_dh[NMB];
   int             m_retry[NMB];
   logic [NMB-1:0] m_pend, m_done, m_lost, m_die, m_lie;
   logic           m_active, m_abort;
   int             m_off;

   task automatic model_reset();
      for (int m = 0; m < NMB; m++) begin
         m_id[m] = '0; m_ext[m] = 0; m_rtr[m] = 0; m_dlc[m] = '0;
         m_dl[m] = '0; m_dh[m] = '0; m_retry[m] = 0;
      end
      m_pend = '0; m_done = '0; m_lost = '0; m_die = '0; m_lie = '0;
      m_active = 0; m_abort = 0; m_off = 0;
   endtask

   function automatic longint key(input int m);
      if (m_ext[m])
         return (longint'(m_id[m] >> 18) << 21) + (64'd1 << 20) + (64'd1 << 19) +
                (longint'(m_id[m] & 29'h3FFFF) << 1) + longint'(m_rtr[m]);
      return (longint'(m_id[m] & 29'h7FF) << 21) + (longint'(m_rtr[m]) << 20);
   endfunction

   function automatic int best();
      int b = -1;
      for (int m = 0; m < NMB; m++)
         if (m_pend[m] && (b < 0 || key(m) < key(b))) b = m;
      return b;
   endfunction

   function automatic logic [31:0] mba(input int m, input int r);
      return 32'((4 * m + r) * 4);
   endfunction

   task automatic mdl_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      int w = int'(adr[7:2]);
      logic [31:0] mk, old, nw;
      mk = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      if (w < 4 * NMB) begin
         int m = w / 4;
         int r = w % 4;
         if (r == 0 && !m_pend[m]) begin
            old = {1'b0, m_rtr[m], m_ext[m], m_id[m]};
            nw = (old & ~mk) | (dat & mk);
            m_id[m] = nw[28:0]; m_ext[m] = nw[29]; m_rtr[m] = nw[30];
         end else if (r == 1) begin
            if (sel[0] && !m_pend[m]) m_dlc[m] = dat[3:0];
            if (sel[1]) begin
               if (dat[9]) begin
                  if (m_pend[m]) begin
                     if (m_active && m_off == m) m_abort = 1;
                     else begin m_pend[m] = 0; m_lost[m] = 1; m_retry[m] = 0; end
                  end
               end else if (dat[8] && !m_pend[m]) begin
                  m_pend[m] = 1; m_retry[m] = 0;
               end
            end
         end else if (r == 2 && !m_pend[m]) begin
            m_dl[m] = (m_dl[m] & ~mk) | (dat & mk);
         end else if (r == 3 && !m_pend[m]) begin
            m_dh[m] = (m_dh[m] & ~mk) | (dat & mk);
         end
      end else if (w == 4 * NMB + 1) begin
         if (sel[1]) m_done = m_done & ~dat[8 +: NMB];
         if (sel[2]) m_lost = m_lost & ~dat[16 +: NMB];
      end else if (w == 4 * NMB + 2) begin
         if (sel[0]) m_die = dat[NMB-1:0];
         if (sel[1]) m_lie = dat[8 +: NMB];
      end
   endtask

   task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
      @(negedge clk);
      wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
      wb_cyc_i = 1; wb_stb_i = 1;
      @(negedge clk);
      check("wb_ack", wb_ack_o, 1);
      rd = wb_dat_o;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      @(negedge clk);
      check("wb_ack_single", wb_ack_o, 0);
   endtask

   task automatic bus_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_cycle(adr, 1, dat, sel, dummy);
      mdl_write(adr, dat, sel);
   endtask

   task automatic bus_rd(input logic [31:0] adr, output logic [31:0] rd);
      wb_cycle(adr, 0, 32'h0, 4'hF, rd);
   endtask

   task automatic load(input int m, input logic [28:0] id, input logic ext, input logic rtr,
                       input logic [3:0] dlc, input logic [31:0] dl, input logic [31:0] dh);
      bus_wr(mba(m, 0), {1'b0, rtr, ext, id}, 4'hF);
      bus_wr(mba(m, 1), {28'b0, dlc}, 4'b0001);
      bus_wr(mba(m, 2), dl, 4'hF);
      bus_wr(mba(m, 3), dh, 4'hF);
   endtask

   task automatic req(input int m);
      bus_wr(mba(m, 1), 32'h100, 4'b0010);
   endtask

   task automatic abort(input int m);
      bus_wr(mba(m, 1), 32'h200, 4'b0010);
   endtask

   task automatic tcu(input logic d, input logic l);
      @(negedge clk);
      tx_done = d; tx_arb_loss = l;
      @(negedge clk);
      tx_done = 0; tx_arb_loss = 0;
      if (m_active) begin
         if (d) begin
            m_pend[m_off] = 0; m_done[m_off] = 1; m_retry[m_off] = 0;
         end else if (l) begin
            m_retry[m_off]++;
            if (m_abort || (MAXR != 0 && m_retry[m_off] == MAXR)) begin
               m_pend[m_off] = 0; m_lost[m_off] = 1; m_retry[m_off] = 0;
            end
         end
         m_active = 0; m_abort = 0;
      end
   endtask

   task automatic settle();
      repeat (5) @(negedge clk);
      if (!m_active && m_pend != '0) begin
         m_active = 1;
         m_off = best();
      end
   endtask

   task automatic check_state();
      logic [31:0] rd, exp;
      check("tx_pkt_ready", tx_pkt_ready, m_active);
      if (m_active) begin
         check("tx_ID", tx_ID, m_id[m_off]);
         check("tx_EXT", tx_EXT, m_ext[m_off]);
         check("tx_RTR", tx_RTR, m_rtr[m_off]);
         check("tx_pkt_size", tx_pkt_size, m_dlc[m_off]);
         check("tx_data", tx_data, {m_dh[m_off], m_dl[m_off]});
      end
      check("irq_o", irq_o, |((m_done & m_die) | (m_lost & m_lie)));
      exp = 32'(m_pend) | (32'(m_done) << 8) | (32'(m_lost) << 16) |
            (32'(m_off) << 24) | (32'(m_active) << 27);
      bus_rd(A_STATUS, rd);
      check("status", rd, exp);
   endtask

   task automatic check_mbx(input int m);
      logic [31:0] rd;
      bus_rd(mba(m, 0), rd); check("rd_id",  rd, {1'b0, m_rtr[m], m_ext[m], m_id[m]});
      bus_rd(mba(m, 1), rd); check("rd_dlc", rd, {28'b0, m_dlc[m]});
      bus_rd(mba(m, 2), rd); check("rd_dl",  rd, m_dl[m]);
      bus_rd(mba(m, 3), rd); check("rd_dh",  rd, m_dh[m]);
   endtask

   initial begin
      logic [31:0] rd, dat;
      logic [3:0]  sel;
      int op, m;

      model_reset();
      repeat (3) @(negedge clk);
      wb_rst_i = 0;
      @(negedge clk);
      check("rst_ready", tx_pkt_ready, 0);
      check("rst_ack", wb_ack_o, 0);
      check("rst_dat", wb_dat_o, 0);
      check("rst_irq", irq_o, 0);
      check("rst_tx_ID", tx_ID, 0);
      check("rst_tx_data", tx_data, 0);
      check_state();

      // Single frame through the queue
      load(0, 29'h123, 0, 0, 4'd8, 32'h0403_0201, 32'h0807_0605);
      req(0);
      settle(); check_state();
      check("t1_id", tx_ID, 29'h123);
      check("t1_data", tx_data, 64'h0807_0605_0403_0201);
      tcu(1, 0);
      settle(); check_state();

      // Priority order: std 0x100, std 0x200, ext with base 0x200
      load(0, 29'h200, 0, 0, 4'd1, 32'h11, 32'h0);
      load(1, 29'h0800_0000, 1, 0, 4'd2, 32'h22, 32'h0);
      load(2, 29'h100, 0, 0, 4'd3, 32'h33, 32'h0);
      req(2); req(1); req(0);
      settle(); check_state(); check("order_first", tx_ID, 29'h100);
      tcu(1, 0);
      settle(); check_state(); check("order_second", tx_ID, 29'h200);
      tcu(1, 0);
      settle(); check_state(); check("order_third", tx_ID, 29'h0800_0000);
      tcu(1, 0);
      settle(); check_state();

      // Retry limit drops the frame and raises the interrupt
      bus_wr(A_IE, 32'h0000_0200, 4'b0011);
      req(1);
      settle(); check_state();
      for (int i = 0; i < MAXR; i++) begin
         tcu(0, 1);
         settle(); check_state();
      end
      check("retry_irq", irq_o, 1);
      bus_wr(A_W1C, 32'h00FF_FF00, 4'b0110);
      settle(); check_state();

      // Abort of the offered frame is deferred, other aborts are immediate
      load(0, 29'h050, 0, 0, 4'd4, 32'hAA, 32'hBB);
      load(1, 29'h300, 0, 1, 4'd5, 32'hCC, 32'hDD);
      req(0); settle(); req(1); settle(); check_state();
      abort(0); abort(1);
      settle(); check_state();
      tcu(0, 1);
      settle(); check_state();

      // Writes to a pending mailbox are dropped; done+loss counts as done
      load(0, 29'h010, 0, 0, 4'd6, 32'h1234, 32'h5678);
      req(0); settle();
      bus_wr(mba(0, 0), 32'h0000_0777, 4'hF);
      bus_wr(mba(0, 2), 32'hFFFF_FFFF, 4'hF);
      check_mbx(0);
      check_state();
      tcu(1, 1);
      settle(); check_state();

      // Unmapped reads
      bus_rd(32'h4C, rd); check("unmapped_4c", rd, 0);
      bus_rd(32'hFC, rd); check("unmapped_fc", rd, 0);
      bus_wr(32'h4C, 32'hFFFF_FFFF, 4'hF);
      settle(); check_state();

      // Randomised traffic
      for (int it = 0; it < 200; it++) begin
         op = $urandom_range(0, 9);
         m  = $urandom_range(0, NMB - 1);
         case (op)
            0, 1, 2: begin
               dat = ($urandom & 32'h6000_0000) | ($urandom & 32'h1804_0600);
               sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
               bus_wr(mba(m, 0), dat, sel);
               bus_wr(mba(m, 1), $urandom & 32'hF, 4'b0001);
               bus_wr(mba(m, 2), $urandom, 4'($urandom_range(0, 15)));
               bus_wr(mba(m, 3), $urandom, 4'hF);
            end
            3, 4: bus_wr(mba(m, 1), 32'h100 | (($urandom_range(0, 7) == 0) ? 32'h200 : 32'h0),
                         ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010);
            5: bus_wr(mba(m, 1), 32'h200, 4'b0010);
            6: bus_wr(A_W1C, $urandom & 32'h00FF_FF00, 4'($urandom_range(0, 15)));
            7: bus_wr(A_IE, $urandom & 32'h0000_FFFF, 4'($urandom_range(0, 15)));
            default: begin
               if (m_active) begin
                  case ($urandom_range(0, 4))
                     0, 1:    tcu(1, 0);
                     2, 3:    tcu(0, 1);
                     default: tcu(1, 1);
                  endcase
               end else begin
                  req(m);
               end
            end
         endcase
         settle();
         check_state();
      end
      for (int k = 0; k < NMB; k++) check_mbx(k);

      // Reset while a frame is offered
      bus_wr(A_IE, 32'h0000_FFFF, 4'b0011);
      load(3, 29'h00F, 0, 0, 4'd2, 32'h1, 32'h2);
      req(3);
      settle(); check_state();
      @(negedge clk);
      wb_rst_i = 1;
      @(negedge clk);
      wb_rst_i = 0;
      model_reset();
      check("rst_mid_ready", tx_pkt_ready, 0);
      check("rst_mid_irq", irq_o, 0);
      check("rst_mid_tx_ID", tx_ID, 0);
      tcu(1, 0);
      settle(); check_state();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
